cavlc_bitstream_ctrl: RTL and testbench
=======================================

Name: cavlc_bitstream_ctrl

Overview:
- Bitstream window controller that feeds the CAVLC syntax decoders (coeff_token, level, total_zeros, run_before).
- Accepts 32-bit MSB-first slice-data words over a valid/ready handshake and buffers them.
- Presents a 16-bit look-ahead window (BitstreamShifted) to the decoders.
- Consumes NumShift bits on each decoder-acknowledged step; also handles byte alignment and flush at slice boundaries.

Parameters:
- BUF_W, 64, bit-buffer depth in bits; must be 2*WORD_W.
- WORD_W, 32, input word width.
- WIN_W, 16, look-ahead window width presented to decoders.

Ports:
- Clk  in  1  clock
- nReset  in  1  synchronous active-low reset
- WordIn  in  32  next slice-data word, bit 31 first in stream order
- WordValid  in  1  WordIn valid
- WordReady  out  1  controller can accept WordIn this cycle
- BitstreamShifted  out  16  next 16 unconsumed bits, bit 15 = next bit
- WindowValid  out  1  at least 16 bits buffered
- ShiftReq  in  1  decoder requests consumption of NumShift bits
- NumShift  in  5  bits to consume, legal range 0..16
- ShiftAck  out  1  shift taken this cycle
- AlignReq  in  1  discard bits up to the next byte boundary
- AlignBusy  out  1  alignment pending
- FlushReq  in  1  drop all buffered bits
- Fill  out  7  buffered bit count, 0..64
- ShiftErr  out  1  sticky; set when NumShift > 16

Behaviour:
- Reset (nReset low at a Clk edge):
  - Buffer cleared; Fill=0; consumed-bit phase ConsPh[2:0]=0.
  - Outputs: WordReady=1, WindowValid=0, BitstreamShifted=0, ShiftAck=0, AlignBusy=0, ShiftErr=0.
  - Reset mid-operation drops all buffered data and any pending align.
- Buffer layout: Buf[63] is the next bit. BitstreamShifted = Buf[63:48]. WindowValid = (Fill >= 16).
- Word accept:
  - WordReady = (Fill <= 32) && !FlushReq; combinational from registered Fill.
  - On WordValid && WordReady, WordIn is written at Buf[63-Fill' -: 32] and Fill' += 32.
  - Fill' is Fill after any same-cycle shift.
  - An accepted word is visible in BitstreamShifted on the next cycle (1-cycle latency).
- Shift:
  - ShiftAck = ShiftReq && WindowValid && !FlushReq; combinational.
  - On ShiftAck: Buf <<= N and Fill -= N, where N = min(NumShift, 16); ConsPh += N mod 8.
  - NumShift > 16: N saturates to 16 and ShiftErr is set.
  - NumShift = 0 is a legal no-op ack.
  - ShiftReq without WindowValid: ignored; the decoder holds the request.
- Simultaneous shift and accept: shift is applied first, then the word is appended at the new Fill. Fill stays ≤ 64 in all cases.
- Align FSM, states RUN and ALIGN:
  - RUN→ALIGN on AlignReq when no ShiftAck that cycle. D = (8 - ConsPh) mod 8.
  - In ALIGN, AlignBusy=1 and ShiftAck is forced to 0.
  - When Fill >= D: discard D bits, ConsPh=0, go to RUN in the same cycle.
  - D = 0 completes in 1 cycle with no discard.
  - AlignReq together with ShiftAck: the shift wins and AlignReq must be held by the requester.
- Flush: FlushReq has highest priority.
  - Next cycle: Fill=0, ConsPh=0, FSM=RUN, buffer cleared.
  - A WordIn presented in the flush cycle is not accepted.
  - ShiftErr is cleared only by reset.
- Arithmetic: Fill is a 7-bit unsigned count, never below 0 or above 64. ConsPh is a 3-bit counter that wraps mod 8.

Optional Feature:
- Macro: CAVLC_BITCOUNT_EN.
- When defined:
  - Adds output ConsumedBits[31:0], total bits removed since the last reset or flush.
  - Counts ShiftAck amounts plus align discards.
  - Wraps at 2^32; cleared by reset and by FlushReq.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then WordIn=0xA5F0_1234 accepted → next cycle Fill=32, WindowValid=1, BitstreamShifted=0xA5F0, WordReady=1.
- Fill=32; ShiftReq with NumShift=5 → ShiftAck=1; next cycle Fill=27, BitstreamShifted=0xBE02 (bits after 5 consumed).
- Fill=48 with WordValid held → WordReady=0. Shift 16 in the same cycle → word still rejected that cycle; accepted next cycle, Fill=64.
- Consume 13 bits (ConsPh=5), then AlignReq → discard 3 bits; Fill drops by 3; ConsPh=0; AlignBusy high exactly 1 cycle.
- Fill=2 with ConsPh=3 and AlignReq → AlignBusy stays 1 and ShiftReq is not acked. After a word is accepted, the 5-bit discard completes and the FSM returns to RUN.
- NumShift=20 with ShiftReq → 16 bits consumed and ShiftErr=1. ShiftErr stays set through FlushReq and clears on nReset=0. With CAVLC_BITCOUNT_EN, ConsumedBits=16 before the flush and 0 after it.

Source files
------------

// File: rtl/cavlc_bitstream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_bitstream_ctrl
// Purpose  : Bitstream window controller feeding the CAVLC syntax decoders.
//            Buffers 32-bit MSB-first slice-data words, presents a 16-bit
//            look-ahead window and consumes bits on decoder request, with
//            byte alignment and flush support at slice boundaries.
// Ports    : Clk, nReset (synchronous, active low)
//            WordIn/WordValid/WordReady     - input word handshake
//            BitstreamShifted/WindowValid   - look-ahead window (bit 15 next)
//            ShiftReq/NumShift/ShiftAck     - bit consumption handshake
//            AlignReq/AlignBusy             - skip to next byte boundary
//            FlushReq                       - drop all buffered bits
//            Fill                           - buffered bit count 0..64
//            ShiftErr                       - sticky, NumShift > 16 seen
//            ConsumedBits (CAVLC_BITCOUNT_EN only) - bits removed since
//                                             reset or flush, wraps at 2^32
// Options  : `define CAVLC_BITCOUNT_EN adds the ConsumedBits counter/port.
// Revision : 1.0 - initial release
// ============================================================================
module cavlc_bitstream_ctrl #(
    parameter int BUF_W  = 64,
    parameter int WORD_W = 32,
    parameter int WIN_W  = 16
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic [WORD_W-1:0] WordIn,
    input  logic              WordValid,
    output logic              WordReady,
    output logic [WIN_W-1:0]  BitstreamShifted,
    output logic              WindowValid,
    input  logic              ShiftReq,
    input  logic [4:0]        NumShift,
    output logic              ShiftAck,
    input  logic              AlignReq,
    output logic              AlignBusy,
    input  logic              FlushReq,
    output logic [6:0]        Fill,
    output logic              ShiftErr
`ifdef CAVLC_BITCOUNT_EN
   ,output logic [31:0]       ConsumedBits
`endif
);

    localparam logic [6:0] c_WIN_BITS     = 7'(WIN_W);
    localparam logic [6:0] c_WORD_BITS    = 7'(WORD_W);
    localparam logic [6:0] c_ACCEPT_LIMIT = 7'(BUF_W - WORD_W);
    localparam logic [4:0] c_MAX_SHIFT    = 5'(WIN_W);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_ALIGN = 1'b1;

    // r_buf[BUF_W-1] is the next bit; everything below r_fill is kept zero so
    // a new word can simply be OR-ed in at the fill point.
    logic [BUF_W-1:0] r_buf;
    logic [6:0]       r_fill;
    logic [2:0]       r_consPh;
    logic [0:0]       r_state;
    logic             r_shiftErr;

    logic             w_windowValid;
    logic             w_wordReady;
    logic             w_shiftAck;
    logic [4:0]       w_shiftAmt;
    logic [2:0]       w_alignD;
    logic             w_alignDone;
    logic [4:0]       w_drop;
    logic [6:0]       w_fillAfter;
    logic             w_accept;
    logic [BUF_W-1:0] w_bufAfter;
    logic [BUF_W-1:0] w_wordPlaced;

    assign w_windowValid = (r_fill >= c_WIN_BITS);
    assign w_wordReady   = (r_fill <= c_ACCEPT_LIMIT) && !FlushReq;
    // Shifts are blocked while an alignment is pending.
    assign w_shiftAck    = ShiftReq && w_windowValid && !FlushReq && (r_state == c_ST_RUN);
    assign w_shiftAmt    = (NumShift > c_MAX_SHIFT) ? c_MAX_SHIFT : NumShift;
    // Bits left to the next byte boundary: (8 - ConsPh) mod 8.
    assign w_alignD      = 3'd0 - r_consPh;
    assign w_alignDone   = (r_state == c_ST_ALIGN) && (r_fill >= {4'd0, w_alignD});

    // A shift and an align discard are mutually exclusive, so one remover
    // path serves both.
    assign w_drop        = w_shiftAck  ? w_shiftAmt :
                           w_alignDone ? {2'd0, w_alignD} : 5'd0;
    assign w_fillAfter   = r_fill - {2'd0, w_drop};
    assign w_accept      = WordValid && w_wordReady;
    assign w_bufAfter    = r_buf << w_drop;
    // The word lands right after the bits that survive this cycle's removal.
    assign w_wordPlaced  = {WordIn, {(BUF_W-WORD_W){1'b0}}} >> w_fillAfter;

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_buf      <= '0;
            r_fill     <= 7'd0;
            r_consPh   <= 3'd0;
            r_state    <= c_ST_RUN;
            r_shiftErr <= 1'b0;
        end else if (FlushReq) begin
            // ShiftErr survives a flush; only reset clears it.
            r_buf    <= '0;
            r_fill   <= 7'd0;
            r_consPh <= 3'd0;
            r_state  <= c_ST_RUN;
        end else begin
            r_buf  <= w_accept ? (w_bufAfter | w_wordPlaced) : w_bufAfter;
            r_fill <= w_accept ? (w_fillAfter + c_WORD_BITS) : w_fillAfter;

            if (w_shiftAck) begin
                r_consPh <= r_consPh + w_shiftAmt[2:0];
                if (NumShift > c_MAX_SHIFT) begin
                    r_shiftErr <= 1'b1;
                end
            end else if (w_alignDone) begin
                r_consPh <= 3'd0;
            end

            case (r_state)
                c_ST_RUN: begin
                    // A same-cycle shift wins; the requester keeps AlignReq up.
                    if (AlignReq && !w_shiftAck) begin
                        r_state <= c_ST_ALIGN;
                    end
                end
                c_ST_ALIGN: begin
                    if (w_alignDone) begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

`ifdef CAVLC_BITCOUNT_EN
    logic [31:0] r_consumed;

    always_ff @(posedge Clk) begin
        if (!nReset || FlushReq) begin
            r_consumed <= 32'd0;
        end else begin
            r_consumed <= r_consumed + {27'd0, w_drop};
        end
    end

    assign ConsumedBits = r_consumed;
`endif

    assign WordReady        = w_wordReady;
    assign BitstreamShifted = r_buf[BUF_W-1 -: WIN_W];
    assign WindowValid      = w_windowValid;
    assign ShiftAck         = w_shiftAck;
    assign AlignBusy        = (r_state == c_ST_ALIGN);
    assign Fill             = r_fill;
    assign ShiftErr         = r_shiftErr;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_bitstream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cavlc_bitstream_ctrl
// Purpose  : Self-checking bench for cavlc_bitstream_ctrl: directed vector
//            table, hand-written align/flush sequences and a randomized run
//            against a bit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cavlc_bitstream_ctrl;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [31:0] WordIn;
    logic        WordValid;
    logic        WordReady;
    logic [15:0] BitstreamShifted;
    logic        WindowValid;
    logic        ShiftReq;
    logic [4:0]  NumShift;
    logic        ShiftAck;
    logic        AlignReq;
    logic        AlignBusy;
    logic        FlushReq;
    logic [6:0]  Fill;
    logic        ShiftErr;
`ifdef CAVLC_BITCOUNT_EN
    logic [31:0] ConsumedBits;
`endif

    always #5 Clk = ~Clk;

    cavlc_bitstream_ctrl dut (
        .Clk              (Clk),
        .nReset           (nReset),
        .WordIn           (WordIn),
        .WordValid        (WordValid),
        .WordReady        (WordReady),
        .BitstreamShifted (BitstreamShifted),
        .WindowValid      (WindowValid),
        .ShiftReq         (ShiftReq),
        .NumShift         (NumShift),
        .ShiftAck         (ShiftAck),
        .AlignReq         (AlignReq),
        .AlignBusy        (AlignBusy),
        .FlushReq         (FlushReq),
        .Fill             (Fill),
        .ShiftErr         (ShiftErr)
`ifdef CAVLC_BITCOUNT_EN
       ,.ConsumedBits     (ConsumedBits)
`endif
    );

    int nVec = 0;
    int nErr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic wv, input logic [31:0] w,
                         input logic sr, input logic [4:0] ns, input logic ar);
        FlushReq  = fl;
        WordValid = wv;
        WordIn    = w;
        ShiftReq  = sr;
        NumShift  = ns;
        AlignReq  = ar;
    endtask

    task automatic nextCycle;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic doReset;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
        nReset = 1'b0;
        @(posedge Clk);
        nextCycle();
        #1;
        check("rst.Fill", 64'(Fill), 64'd0);
        check("rst.WindowValid", 64'(WindowValid), 64'd0);
        check("rst.Bitstream", 64'(BitstreamShifted), 64'd0);
        check("rst.WordReady", 64'(WordReady), 64'd1);
        check("rst.ShiftAck", 64'(ShiftAck), 64'd0);
        check("rst.AlignBusy", 64'(AlignBusy), 64'd0);
        check("rst.ShiftErr", 64'(ShiftErr), 64'd0);
        nReset = 1'b1;
    endtask

    // Directed per-cycle vectors: inputs for the cycle and the outputs
    // expected during that cycle (before its clock edge).
    typedef struct {
        logic        fl;
        logic        wv;
        logic [31:0] word;
        logic        sr;
        logic [4:0]  ns;
        logic        ar;
        logic [6:0]  eFill;
        logic [15:0] eBs;
        logic        eWv;
        logic        eWr;
        logic        eAck;
        logic        eBusy;
    } vec_t;

    localparam int c_NV = 13;
    vec_t tbl [c_NV];

    // Reference model: buffered bits as a queue, front = next bit.
    bit          mq [$];
    int          mPh;
    bit          mAlign;
    bit          mErr;
    int unsigned mCons;

    task automatic modelReset;
        mq.delete();
        mPh    = 0;
        mAlign = 0;
        mErr   = 0;
        mCons  = 0;
    endtask

    function automatic logic [15:0] modelWin();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < mq.size()) v[15-i] = mq[i];
        end
        return v;
    endfunction

    task automatic randomStep(input int cyc);
        logic        fl, wv, sr, ar;
        logic [31:0] w;
        logic [4:0]  ns;
        bit          expWr, expAck, wasAlign;
        int          n, d;
        fl = (($urandom % 64) == 0);
        wv = 1'($urandom % 2);
        w  = $urandom;
        sr = 1'($urandom % 2);
        ns = (($urandom % 16) == 0) ? 5'($urandom_range(31, 17)) : 5'($urandom_range(16, 0));
        ar = (($urandom % 12) == 0);
        drive(fl, wv, w, sr, ns, ar);
        #1;
        expWr  = (mq.size() <= 32) && !fl;
        expAck = sr && (mq.size() >= 16) && !fl && !mAlign;
        check($sformatf("rnd%0d.Fill", cyc), 64'(Fill), 64'(mq.size()));
        check($sformatf("rnd%0d.WindowValid", cyc), 64'(WindowValid), 64'(mq.size() >= 16));
        check($sformatf("rnd%0d.Bitstream", cyc), 64'(BitstreamShifted), 64'(modelWin()));
        check($sformatf("rnd%0d.WordReady", cyc), 64'(WordReady), 64'(expWr));
        check($sformatf("rnd%0d.ShiftAck", cyc), 64'(ShiftAck), 64'(expAck));
        check($sformatf("rnd%0d.AlignBusy", cyc), 64'(AlignBusy), 64'(mAlign));
        check($sformatf("rnd%0d.ShiftErr", cyc), 64'(ShiftErr), 64'(mErr));
`ifdef CAVLC_BITCOUNT_EN
        check($sformatf("rnd%0d.ConsumedBits", cyc), 64'(ConsumedBits), 64'(mCons));
`endif
        @(posedge Clk);
        if (fl) begin
            mq.delete();
            mPh    = 0;
            mAlign = 0;
            mCons  = 0;
        end else begin
            wasAlign = mAlign;
            if (expAck) begin
                n = (ns > 16) ? 16 : int'(ns);
                if (ns > 16) mErr = 1;
                repeat (n) void'(mq.pop_front());
                mPh   = (mPh + n) % 8;
                mCons = mCons + n;
            end else if (wasAlign) begin
                d = (8 - mPh) % 8;
                if (mq.size() >= d) begin
                    repeat (d) void'(mq.pop_front());
                    mPh    = 0;
                    mAlign = 0;
                    mCons  = mCons + d;
                end
            end
            if (!wasAlign && ar && !expAck) mAlign = 1;
            if (wv && expWr) begin
                for (int b = 31; b >= 0; b--) mq.push_back(w[b]);
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        //          fl  wv  word          sr  ns     ar   Fill   Bs        Wv Wr Ack Busy
        tbl[0]  = '{0, 1, 32'hA5F0_1234, 0, 5'd0,  0, 7'd0,  16'h0000, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 32'h0,         1, 5'd5,  0, 7'd32, 16'hA5F0, 1, 1, 1, 0};
        tbl[2]  = '{0, 0, 32'h0,         0, 5'd0,  0, 7'd27, 16'hBE02, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 32'h0,         1, 5'd11, 0, 7'd27, 16'hBE02, 1, 1, 1, 0};
        tbl[4]  = '{0, 1, 32'hCAFE_BABE, 0, 5'd0,  0, 7'd16, 16'h1234, 1, 1, 0, 0};
        tbl[5]  = '{0, 1, 32'h0F0F_0F0F, 1, 5'd16, 0, 7'd48, 16'h1234, 1, 0, 1, 0};
        tbl[6]  = '{0, 1, 32'h0F0F_0F0F, 0, 5'd0,  0, 7'd32, 16'hCAFE, 1, 1, 0, 0};
        tbl[7]  = '{0, 0, 32'h0,         1, 5'd13, 0, 7'd64, 16'hCAFE, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 32'h0,         0, 5'd0,  1, 7'd51, 16'hD757, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 32'h0,         1, 5'd4,  0, 7'd51, 16'hD757, 1, 0, 0, 1};
        tbl[10] = '{0, 0, 32'h0,         0, 5'd0,  0, 7'd48, 16'hBABE, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 32'h0,         1, 5'd16, 0, 7'd48, 16'hBABE, 1, 0, 1, 0};
        tbl[12] = '{0, 0, 32'h0,         0, 5'd0,  0, 7'd32, 16'h0F0F, 1, 1, 0, 0};

        nReset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);
        @(negedge Clk);

        // Directed table.
        doReset();
        for (int i = 0; i < c_NV; i++) begin
            drive(tbl[i].fl, tbl[i].wv, tbl[i].word, tbl[i].sr, tbl[i].ns, tbl[i].ar);
            #1;
            check($sformatf("vec%0d.Fill", i), 64'(Fill), 64'(tbl[i].eFill));
            check($sformatf("vec%0d.Bitstream", i), 64'(BitstreamShifted), 64'(tbl[i].eBs));
            check($sformatf("vec%0d.WindowValid", i), 64'(WindowValid), 64'(tbl[i].eWv));
            check($sformatf("vec%0d.WordReady", i), 64'(WordReady), 64'(tbl[i].eWr));
            check($sformatf("vec%0d.ShiftAck", i), 64'(ShiftAck), 64'(tbl[i].eAck));
            check($sformatf("vec%0d.AlignBusy", i), 64'(AlignBusy), 64'(tbl[i].eBusy));
            nextCycle();
        end

        // Align with only 2 bits buffered (ConsPh=6), then an align already
        // on a byte boundary.
        doReset();
        drive(0, 1, 32'h89AB_CDEF, 0, 5'd0, 0);  nextCycle();
        drive(0, 0, 32'd0, 1, 5'd16, 0);          nextCycle();
        drive(0, 0, 32'd0, 1, 5'd14, 0);          nextCycle();
        drive(0, 0, 32'd0, 0, 5'd0, 1);
        #1;
        check("alnA.Fill", 64'(Fill), 64'd2);
        check("alnA.Bitstream", 64'(BitstreamShifted), 64'hC000);
        check("alnA.AlignBusy", 64'(AlignBusy), 64'd0);
        nextCycle();
        drive(0, 0, 32'd0, 1, 5'd1, 0);
        #1;
        check("alnA.BusyHigh", 64'(AlignBusy), 64'd1);
        check("alnA.AckBlocked", 64'(ShiftAck), 64'd0);
        nextCycle();
        drive(0, 0, 32'd0, 0, 5'd0, 1);
        #1;
        check("alnA.BusyLow", 64'(AlignBusy), 64'd0);
        check("alnA.FillAfter", 64'(Fill), 64'd0);
        nextCycle();
        drive(0, 0, 32'd0, 0, 5'd0, 0);
        #1;
        check("alnB.BusyHigh", 64'(AlignBusy), 64'd1);
        nextCycle();
        #1;
        check("alnB.BusyLow", 64'(AlignBusy), 64'd0);
        check("alnB.Fill", 64'(Fill), 64'd0);

        // Oversized shift, sticky error through flush, cleared by reset.
        doReset();
        drive(0, 1, 32'h1357_9BDF, 0, 5'd0, 0);  nextCycle();
        drive(0, 0, 32'd0, 1, 5'd20, 0);
        #1;
        check("err.ShiftAck", 64'(ShiftAck), 64'd1);
        nextCycle();
        drive(1, 1, 32'hFFFF_FFFF, 1, 5'd4, 0);
        #1;
        check("err.Fill", 64'(Fill), 64'd16);
        check("err.Bitstream", 64'(BitstreamShifted), 64'h9BDF);
        check("err.ShiftErr", 64'(ShiftErr), 64'd1);
        check("flush.WordReady", 64'(WordReady), 64'd0);
        check("flush.ShiftAck", 64'(ShiftAck), 64'd0);
`ifdef CAVLC_BITCOUNT_EN
        check("err.ConsumedBits", 64'(ConsumedBits), 64'd16);
`endif
        nextCycle();
        drive(0, 0, 32'd0, 0, 5'd0, 0);
        #1;
        check("flush.Fill", 64'(Fill), 64'd0);
        check("flush.Bitstream", 64'(BitstreamShifted), 64'd0);
        check("flush.ShiftErrKept", 64'(ShiftErr), 64'd1);
`ifdef CAVLC_BITCOUNT_EN
        check("flush.ConsumedBits", 64'(ConsumedBits), 64'd0);
`endif
        nextCycle();
        doReset();

        // Randomized run against the model, with a reset in the middle.
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                doReset();
                modelReset();
            end
            randomStep(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
